// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_LATENCY     = 2;

    function automatic int index_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

    // Wide enough to hold LATENCY-1, never narrower than one bit.
    function automatic int counter_width(input int latency);
        return (latency < 2) ? 1 : $clog2(latency);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Memory-stage request/response bus between the core (master) and the responder (slave).
interface dmem_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word array: synchronous write, asynchronous read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [index_width(DEPTH_WORDS)-1:0] addr,
    input  logic [31:0]                         wdata,
    output logic [31:0]                         rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed LATENCY, single-cycle response.
// Optional misaligned-access error reporting is enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic  clk,
    input  logic  rst,
    dmem_if.slave bus
);

    localparam int IW = index_width(DEPTH_WORDS);
    localparam int CW = counter_width(LATENCY);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          rsp_valid_q;
    logic          lat_we;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;

    logic          accept;
    logic          misaligned;
    logic          mem_we;
    logic [31:0]   mem_rdata;
    logic [IW-1:0] word_index;
    logic          unused_addr_bits;

    assign bus.req_ready = (state == IDLE) || (state == RESP);
    assign accept        = bus.req_valid && bus.req_ready;

    // Upper address bits are dropped so accesses wrap modulo the array size.
    assign word_index       = lat_addr[IW+1:2];
    assign unused_addr_bits = ^{lat_addr[31:IW+2], lat_addr[1:0]};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misaligned = (lat_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // The store lands on the edge that closes its RESP cycle, so a load accepted then sees it.
    assign mem_we = rsp_valid_q && lat_we && !misaligned;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .addr (word_index),
        .wdata(lat_wdata),
        .rdata(mem_rdata)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = (rsp_valid_q && !lat_we && !misaligned) ? mem_rdata : 32'h0;
    assign bus.rsp_err   = rsp_valid_q && misaligned;
    assign bus.busy      = (state != IDLE) && !(rsp_valid_q && !accept);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            lat_we      <= 1'b0;
            lat_addr    <= 32'h0;
            lat_wdata   <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        lat_we    <= bus.req_we;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        if (LATENCY == 1) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(LATENCY - 1);
                        end
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                WAIT: begin
                    if (cnt == CW'(1)) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench: LATENCY 2 main instance plus LATENCY 1 and 3 instances.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_if bus1 ();
    dmem_if bus2 ();
    dmem_if bus3 ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int checkCount = 0;
    int passCount  = 0;

    logic        l3We    [4];
    logic [31:0] l3Addr  [4];
    logic [31:0] l3Wdata [4];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // One request on the LATENCY=2 instance; lat counts negedges from accept to rsp_valid.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_we    = we;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        lat = 1;
        while (!bus2.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus2.rsp_rdata;
        err   = bus2.rsp_err;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        expValid, expReady, expBusy;

        l3We    = '{1'b1, 1'b1, 1'b0, 1'b0};
        l3Addr  = '{32'h0, 32'h4, 32'h0, 32'h4};
        l3Wdata = '{32'h30303030, 32'h34343434, 32'h0, 32'h0};

        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 32'h0; bus2.req_wdata = 32'h0;
        bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_addr = 32'h0; bus3.req_wdata = 32'h0;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(bus2.req_ready), 32'd1);
        checkOutput("rst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        checkOutput("rst_rdata", bus2.rsp_rdata, 32'h0);
        checkOutput("rst_err", 32'(bus2.rsp_err), 32'd0);
        checkOutput("rst_busy", 32'(bus2.busy), 32'd0);
        rst = 1'b0;

        // Store then load at LATENCY 2.
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        checkOutput("st_lat", 32'(lat), 32'd2);
        checkOutput("st_rdata", rd, 32'h0);
        checkOutput("st_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, rd, er, lat);
        checkOutput("ld_lat", 32'(lat), 32'd2);
        checkOutput("ld_rdata", rd, 32'hDEADBEEF);
        checkOutput("ld_err", 32'(er), 32'd0);

        // 0x400 aliases word 0 in a 256-word array.
        applyStimulus(1'b1, 32'h400, 32'hA5A5A5A5, rd, er, lat);
        applyStimulus(1'b0, 32'h000, 32'h0, rd, er, lat);
        checkOutput("wrap_rdata", rd, 32'hA5A5A5A5);
        applyStimulus(1'b0, 32'h10, 32'h0, rd, er, lat);
        checkOutput("wrap_other_word", rd, 32'hDEADBEEF);

        // Reset during WAIT drops the store.
        applyStimulus(1'b1, 32'h40, 32'hCAFEF00D, rd, er, lat);
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 32'h40; bus2.req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        checkOutput("mid_busy_before", 32'(bus2.busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 32'(bus2.rsp_valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(bus2.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_no_rsp_%0d", i), 32'(bus2.rsp_valid), 32'd0);
        end
        applyStimulus(1'b0, 32'h40, 32'h0, rd, er, lat);
        checkOutput("mid_retained", rd, 32'hCAFEF00D);

        // Misaligned store to 0x42.
        applyStimulus(1'b1, 32'h42, 32'hBBBBBBBB, rd, er, lat);
        checkOutput("mis_lat", 32'(lat), 32'd2);
        checkOutput("mis_rdata", rd, 32'h0);
`ifdef DMEM_MISALIGN_CHECK_EN
        checkOutput("mis_err", 32'(er), 32'd1);
        applyStimulus(1'b0, 32'h40, 32'h0, rd, er, lat);
        checkOutput("mis_word_kept", rd, 32'hCAFEF00D);
        applyStimulus(1'b0, 32'h43, 32'h0, rd, er, lat);
        checkOutput("mis_ld_err", 32'(er), 32'd1);
        checkOutput("mis_ld_rdata", rd, 32'h0);
`else
        checkOutput("mis_err", 32'(er), 32'd0);
        applyStimulus(1'b0, 32'h40, 32'h0, rd, er, lat);
        checkOutput("mis_word_written", rd, 32'hBBBBBBBB);
        applyStimulus(1'b0, 32'h43, 32'h0, rd, er, lat);
        checkOutput("mis_ld_err", 32'(er), 32'd0);
        checkOutput("mis_ld_rdata", rd, 32'hBBBBBBBB);
`endif

        // LATENCY 1: load accepted in the store's RESP cycle sees the new data.
        @(negedge clk);
        bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 32'h20; bus1.req_wdata = 32'h11111111;
        #1;
        checkOutput("l1_ready_idle", 32'(bus1.req_ready), 32'd1);
        @(negedge clk);
        checkOutput("l1_st_valid", 32'(bus1.rsp_valid), 32'd1);
        checkOutput("l1_st_rdata", bus1.rsp_rdata, 32'h0);
        bus1.req_we = 1'b0; bus1.req_wdata = 32'h0;
        #1;
        checkOutput("l1_ready_resp", 32'(bus1.req_ready), 32'd1);
        checkOutput("l1_busy_b2b", 32'(bus1.busy), 32'd1);
        @(negedge clk);
        bus1.req_valid = 1'b0;
        #1;
        checkOutput("l1_ld_valid", 32'(bus1.rsp_valid), 32'd1);
        checkOutput("l1_ld_rdata", bus1.rsp_rdata, 32'h11111111);
        checkOutput("l1_ready_ld", 32'(bus1.req_ready), 32'd1);
        checkOutput("l1_busy_last", 32'(bus1.busy), 32'd0);
        @(negedge clk);
        checkOutput("l1_idle_valid", 32'(bus1.rsp_valid), 32'd0);

        // LATENCY 3: four requests with req_valid held continuously.
        @(negedge clk);
        bus3.req_valid = 1'b1; bus3.req_we = l3We[0]; bus3.req_addr = l3Addr[0]; bus3.req_wdata = l3Wdata[0];
        @(posedge clk);
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            expValid = (k % 3 == 0);
            expReady = (k % 3 == 0) || (k == 13);
            expBusy  = (k < 12);
            checkOutput($sformatf("l3_valid_k%0d", k), 32'(bus3.rsp_valid), 32'(expValid));
            checkOutput($sformatf("l3_ready_k%0d", k), 32'(bus3.req_ready), 32'(expReady));
            checkOutput($sformatf("l3_busy_k%0d", k), 32'(bus3.busy), 32'(expBusy));
            if (k == 9)  checkOutput("l3_ld0_rdata", bus3.rsp_rdata, 32'h30303030);
            if (k == 12) checkOutput("l3_ld1_rdata", bus3.rsp_rdata, 32'h34343434);
            if (k == 1 || k == 4 || k == 7) begin
                bus3.req_we    = l3We[k / 3 + 1];
                bus3.req_addr  = l3Addr[k / 3 + 1];
                bus3.req_wdata = l3Wdata[k / 3 + 1];
            end
            if (k == 10) bus3.req_valid = 1'b0;
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
